// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - constants and FSM state type for the instruction-memory loader
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CK_HI/CK_LO checksum states.
package imem_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 16;
  localparam int ADDR_W_DEFAULT = 8;

  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    W_HI,
    W_LO,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CK_HI,
    CK_LO,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/imem_loader_cksum.sv
// rtl/imem_loader_cksum.sv - modulo-2^16 running sum of loaded instruction words
// Only instantiated when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader_cksum
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= '0;
    end else if (add) begin
      value <= value + word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a counted, high-byte-first program into instruction memory
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN appends and verifies a 16-bit word checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_WORDS = CK_HI;
`else
  localparam state_t AFTER_WORDS = DONE;
`endif

  state_t              state, state_n;
  logic [BYTE_W-1:0]   hi_q, lo_q;
  logic [WORD_W-1:0]   count_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                full_q;   // every address has been written once; later words are dropped
  logic                drop_q;
  logic                err_q;
  logic                xfer, load, ck_bad;
  logic [WORD_W-1:0]   rx_word;

  assign xfer    = in_valid && in_ready;
  assign load    = start && (state == IDLE || state == DONE);
  assign rx_word = {hi_q, in_data};

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;

  imem_loader_cksum u_cksum (
    .clk   (clk),
    .reset (reset),
    .clear (load),
    .add   (state == WRITE),
    .word  ({hi_q, lo_q}),
    .value (sum)
  );

  assign ck_bad = (state == CK_LO) && (rx_word != sum);
`else
  assign ck_bad = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_n = CNT_HI;
      CNT_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_n = CNT_LO;
      end
      CNT_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (rx_word == '0) ? AFTER_WORDS : W_HI;
      end
      W_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_n = W_LO;
      end
      W_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_n = WRITE;
      end
      WRITE: state_n = (count_q == 16'd1) ? AFTER_WORDS : W_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CK_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_n = CK_LO;
      end
      CK_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_n = DONE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
      addr_q  <= '0;
      full_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        count_q <= '0;
        addr_q  <= '0;
        full_q  <= 1'b0;
        drop_q  <= 1'b0;
        err_q   <= 1'b0;
      end
      if (xfer) begin
        case (state)
          CNT_LO:  count_q <= rx_word;
          W_LO:    lo_q    <= in_data;
          default: hi_q    <= in_data;
        endcase
      end
      if (state == WRITE) begin
        count_q <= count_q - 1'b1;
        if (full_q)        drop_q <= 1'b1;
        else if (&addr_q)  full_q <= 1'b1;
        else               addr_q <= addr_q + 1'b1;
      end
      // The drop of the very last word lands in the same cycle as entering DONE.
      if (state_n == DONE && state != DONE && !load)
        err_q <= drop_q || (state == WRITE && full_q) || ck_bad;
    end
  end

  assign imem_we    = (state == WRITE) && !full_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = {hi_q, lo_q};
  assign done       = (state == DONE);
  assign err        = err_q;
  assign cpu_reset  = !(done && !err_q);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a word-list reference model
// Honours IMEM_LOADER_CHECKSUM_EN to append checksums to each stream.
module tb_imem_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, imem_we, cpu_reset, done, err;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cap_addr[$];
  logic [15:0] cap_data[$];
  logic [15:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory-side monitor: record every write and make sure no byte is taken while writing.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      cap_addr.push_back(int'(imem_addr));
      cap_data.push_back(imem_wdata);
      chk("ready_in_write", {31'd0, in_ready}, 32'd0);
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    chk({tag, "_imem_we"},   {31'd0, imem_we},   32'd0);
    chk({tag, "_imem_addr"}, {30'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"},     {16'd0, imem_wdata}, 32'd0);
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    chk({tag, "_done"},      {31'd0, done},      32'd0);
    chk({tag, "_err"},       {31'd0, err},       32'd0);
  endtask

  // Called and returns on a falling edge; the byte transfers on the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_data = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("handshake_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [15:0] w, input bit gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[7:0], gaps);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", {31'd0, done}, 32'd1);
  endtask

  // Streams wq; the reference expects the first DEPTH words at consecutive addresses.
  task automatic run_load(input bit gaps, input bit mid_start, input logic [15:0] ck_delta);
    int          cnt = wq.size();
    int          nw  = (cnt < DEPTH) ? cnt : DEPTH;
    logic [15:0] sum = 16'd0;
    logic [15:0] c16 = 16'(cnt);
    bit          exp_err;
    cap_addr.delete();
    cap_data.delete();
    foreach (wq[i]) sum += wq[i];
    exp_err = (cnt > DEPTH) || (CK_EN && ck_delta != 16'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(c16, gaps);
    foreach (wq[i]) begin
      send_word(wq[i], gaps);
      if (mid_start && i == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    if (CK_EN) send_word(sum + ck_delta, gaps);
    wait_done();

    chk("write_count", cap_addr.size(), nw);
    for (int i = 0; i < nw && i < cap_addr.size(); i++) begin
      chk($sformatf("waddr%0d", i), cap_addr[i], i);
      chk($sformatf("wdata%0d", i), {16'd0, cap_data[i]}, {16'd0, wq[i]});
    end
    chk("err",       {31'd0, err},       {31'd0, exp_err});
    chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, exp_err});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    reset = 1'b0;
    @(negedge clk);

    wq = {16'h1234, 16'hABCD, 16'h0001};
    run_load(1'b0, 1'b0, 16'd0);
    run_load(1'b1, 1'b0, 16'd0);

    wq = {};
    run_load(1'b0, 1'b0, 16'd0);

    wq = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    run_load(1'b0, 1'b0, 16'd0);

    wq = {16'hF00D, 16'h0BAD, 16'hCAFE, 16'hBEEF};
    run_load(1'b1, 1'b0, 16'd0);

    wq = {16'h0001, 16'h0002};
    run_load(1'b0, 1'b0, 16'd1);
    run_load(1'b0, 1'b0, 16'd0);

    wq = {16'h0A0B, 16'h0C0D, 16'h0E0F};
    run_load(1'b1, 1'b1, 16'd0);

    // Reset lands after the second word has been accepted.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(16'd3, 1'b0);
    send_word(16'h7777, 1'b0);
    send_word(16'h8888, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("midload");
    reset = 1'b0;
    @(negedge clk);
    wq = {16'h9999, 16'hAAAA, 16'hBBBB};
    run_load(1'b0, 1'b0, 16'd0);

    for (int k = 0; k < 8; k++) begin
      wq = {};
      repeat ($urandom_range(0, 6)) wq.push_back(16'($urandom));
      run_load(1'($urandom_range(0, 1)), 1'b0,
               ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 16'hFFFF)) : 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
